alu_cmd_issuer: RTL and testbench

- Upstream driver stage for the tiny ALU.
- Accepts operation commands on a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the ALU using its level-start protocol, then returns the captured result, or an error/timeout status, on a valid/ready response interface.
- Decouples bursty command producers (testbench BFM, sequencer logic) from the ALU's variable 1- or 3-cycle latency.

---
 rtl/alu_cmd_issuer.sv | 203 ++++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands in a small FIFO, issues them with a level
// start held until done or timeout, and returns one response per command.
`default_nettype none

module alu_cmd_issuer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic        rsp_timeout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // ---------------- command FIFO ----------------
    logic [18:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          push, pop;
    logic [18:0]   head;

    assign push = cmd_valid && ready_q;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        // Registered ready: reflects the occupancy that will exist after this edge.
        ready_d = (count_d != CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // ---------------- issue FSM ----------------
    state_t        state_q, state_d;
    logic          start_q, start_d;
    logic [2:0]    alu_op_q, alu_op_d;
    logic [7:0]    alu_a_q, alu_a_d;
    logic [7:0]    alu_b_q, alu_b_d;
    logic [2:0]    op_q, op_d;
    logic [15:0]   result_q, result_d;
    logic          err_q, err_d;
    logic          tmo_q, tmo_d;
    logic [7:0]    cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        start_d  = start_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        op_d     = op_q;
        result_d = result_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    op_d     = head[18:16];
                    result_d = '0;
                    err_d    = 1'b0;
                    tmo_d    = 1'b0;
                    case (head[18:16])
                        3'b001, 3'b010, 3'b011, 3'b100: begin
                            start_d  = 1'b1;
                            alu_op_d = head[18:16];
                            alu_a_d  = head[15:8];
                            alu_b_d  = head[7:0];
                            cnt_d    = '0;
                            state_d  = S_ISSUE;
                        end
                        3'b000:  state_d = S_RESP;
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_RESP;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                // done takes priority over an expiring timeout in the same cycle
                if (alu_done) begin
                    result_d = alu_result;
                    start_d  = 1'b0;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(TIMEOUT)) begin
                        start_d  = 1'b0;
                        result_d = '0;
                        tmo_d    = 1'b1;
                        state_d  = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            op_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign alu_start   = start_q;
    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_result  = result_q;
    assign rsp_op      = op_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed self-checking bench with a small ALU model
// (1-cycle add/and/xor, 3-cycle mul, optional never-done mode).
`default_nettype none

module tb_alu_cmd_issuer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic        rsp_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    alu_cmd_issuer #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    // ALU model plus start monitor, both evaluated away from the active edge.
    logic       alu_en = 1'b1;
    int         lat = 0;
    int         hi_cnt = 0;
    int         starts = 0;
    int         unstable = 0;
    logic       prev_start = 1'b0;
    logic [18:0] prev_cmd = '0;

    initial begin
        alu_done   = 1'b0;
        alu_result = '0;
    end

    always @(negedge clk) begin
        if (!alu_start || !alu_en) begin
            alu_done = 1'b0;
            lat      = 0;
        end else if (!alu_done) begin
            lat++;
            if (lat >= ((alu_op == 3'b100) ? 3 : 1)) begin
                alu_done = 1'b1;
                case (alu_op)
                    3'b001:  alu_result = {8'h00, alu_a} + {8'h00, alu_b};
                    3'b010:  alu_result = {8'h00, alu_a & alu_b};
                    3'b011:  alu_result = {8'h00, alu_a ^ alu_b};
                    default: alu_result = {8'h00, alu_a} * {8'h00, alu_b};
                endcase
            end
        end
        if (alu_start) begin
            hi_cnt++;
            if (!prev_start) starts++;
            else if (prev_cmd != {alu_op, alu_a, alu_b}) unstable++;
        end
        prev_start = alu_start;
        prev_cmd   = {alu_op, alu_a, alu_b};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("push_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for a response, checks it, and lets the handshake complete.
    task automatic get_rsp(input string tag, input logic [15:0] e_res, input logic [2:0] e_op,
                           input logic e_err, input logic e_to);
        int n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check({tag, "_wait"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_res"}, 32'(rsp_result), 32'(e_res));
            check({tag, "_op"},  32'(rsp_op),     32'(e_op));
            check({tag, "_err"}, 32'(rsp_err),    32'(e_err));
            check({tag, "_to"},  32'(rsp_timeout), 32'(e_to));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int seen;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 check("post_rst_ready", 32'(cmd_ready), 32'd1);

        // add with carry into bit 8
        hi_cnt = 0;
        push(3'b001, 8'hFF, 8'h01);
        get_rsp("add", 16'h0100, 3'b001, 1'b0, 1'b0);
        check("add_start_cycles", 32'(hi_cnt), 32'd1);

        // 3-cycle mul with stable operands
        hi_cnt = 0;
        unstable = 0;
        push(3'b100, 8'hFF, 8'hFF);
        get_rsp("mul", 16'hFE01, 3'b100, 1'b0, 1'b0);
        check("mul_start_cycles", 32'(hi_cnt), 32'd3);
        check("mul_stable", 32'(unstable), 32'd0);

        // DEPTH+1 commands with the consumer stalled
        rsp_ready = 1'b0;
        push(3'b001, 8'h10, 8'h0E);
        push(3'b010, 8'hF0, 8'h3C);
        push(3'b011, 8'hAA, 8'h55);
        push(3'b100, 8'h10, 8'h10);
        push(3'b001, 8'h80, 8'h80);
        @(negedge clk);
        check("full_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_result", 32'(rsp_result), 32'h001E);
        end
        rsp_ready = 1'b1;
        get_rsp("q0", 16'h001E, 3'b001, 1'b0, 1'b0);
        get_rsp("q1", 16'h0030, 3'b010, 1'b0, 1'b0);
        get_rsp("q2", 16'h00FF, 3'b011, 1'b0, 1'b0);
        get_rsp("q3", 16'h0100, 3'b100, 1'b0, 1'b0);
        get_rsp("q4", 16'h0100, 3'b001, 1'b0, 1'b0);

        // no_op, unsupported, xor
        s0 = starts;
        rsp_ready = 1'b0;
        push(3'b000, 8'h12, 8'h34);
        push(3'b110, 8'h56, 8'h78);
        push(3'b011, 8'hF0, 8'h3C);
        rsp_ready = 1'b1;
        get_rsp("noop", 16'h0000, 3'b000, 1'b0, 1'b0);
        get_rsp("bad_op", 16'h0000, 3'b110, 1'b1, 1'b0);
        get_rsp("xor", 16'h00CC, 3'b011, 1'b0, 1'b0);
        check("noop_bad_starts", 32'(starts - s0), 32'd1);

        // ALU never completes -> timeout, then the next command runs normally
        alu_en = 1'b0;
        hi_cnt = 0;
        rsp_ready = 1'b0;
        push(3'b001, 8'h01, 8'h02);
        push(3'b001, 8'h03, 8'h04);
        rsp_ready = 1'b1;
        get_rsp("tmo", 16'h0000, 3'b001, 1'b0, 1'b1);
        check("tmo_start_cycles", 32'(hi_cnt), 32'd15);
        alu_en = 1'b1;
        get_rsp("after_tmo", 16'h0007, 3'b001, 1'b0, 1'b0);

        // reset while in ISSUE with two commands queued
        alu_en = 1'b0;
        push(3'b100, 8'h02, 8'h03);
        push(3'b001, 8'h05, 8'h06);
        push(3'b001, 8'h07, 8'h08);
        @(negedge clk);
        check("pre_rst_start", 32'(alu_start), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_start", 32'(alu_start), 32'd0);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        alu_en = 1'b1;
        s0     = starts;
        seen   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("no_stale_rsp", 32'(seen), 32'd0);
        check("no_stale_start", 32'(starts - s0), 32'd0);
        check("rst_ready_back", 32'(cmd_ready), 32'd1);
        push(3'b010, 8'hF0, 8'h3C);
        get_rsp("post_rst_and", 16'h0030, 3'b010, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
